// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
// Holds the FSM state encoding, the default operand width and the counter width helper.
package shift_add_mult_ctrl_pkg;

    localparam int unsigned DEFAULT_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Step counter must hold 0..W-1; a single-bit counter is the floor.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result handshake bundle for shift_add_mult_ctrl.
// master: operand source + result consumer; slave: the multiplier controller.
interface shift_add_mult_ctrl_if
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
);

    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/shift_add_mult_ctrl_add_level.sv
// Single W-bit ripple-carry adder level shared by every shift-and-add step.
// Built from one half_adder at bit 0 followed by a chain of full_adders.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module add_level #(
    parameter int unsigned W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         c_out
);

    // carry[i] is the carry into bit i; carry[W] leaves the level.
    logic [W:1] carry;

    half_adder u_ha0 (
        .a (a[0]),
        .b (b[0]),
        .s (sum[0]),
        .c (carry[1])
    );

    for (genvar i = 1; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .s     (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[W];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one shared adder level, W steps per product.
// Optional build macro ZERO_SKIP_EN: zero operands finish on the accept edge without RUN.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult_ctrl_if.slave  bus
);

    localparam int unsigned CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    state_t          state,   state_d;
    logic [CW-1:0]   cnt,     cnt_d;
    logic [W-1:0]    mcand,   mcand_d;
    logic [W-1:0]    acc_hi,  acc_hi_d;
    logic [W-1:0]    lo,      lo_d;
    logic [2*W-1:0]  product, product_d;
    logic            busy,    busy_d;
    logic            done,    done_d;

    logic [W-1:0]    addend;
    logic [W-1:0]    sum;
    logic            sum_c;
    logic            zero_skip;

    // Gating the addend is equivalent to choosing between acc_hi+mcand and {0,acc_hi}.
    assign addend = lo[0] ? mcand : '0;

    add_level #(.W(W)) u_add_level (
        .a     (acc_hi),
        .b     (addend),
        .sum   (sum),
        .c_out (sum_c)
    );

`ifdef ZERO_SKIP_EN
    assign zero_skip = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        mcand_d   = mcand;
        acc_hi_d  = acc_hi;
        lo_d      = lo;
        product_d = product;
        busy_d    = busy;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (zero_skip) begin
                        product_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        mcand_d  = bus.a;
                        acc_hi_d = '0;
                        lo_d     = bus.b;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end
                end
            end

            RUN: begin
                // Carry out of the adder becomes the new MSB of the shifted accumulator.
                acc_hi_d = {sum_c, sum[W-1:1]};
                lo_d     = {sum[0], lo[W-1:1]};
                cnt_d    = cnt + 1'b1;
                if (cnt == LAST_STEP) begin
                    product_d = {acc_hi_d, lo_d};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            lo      <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            mcand   <= mcand_d;
            acc_hi  <= acc_hi_d;
            lo      <= lo_d;
            product <= product_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed self-checking bench for shift_add_mult_ctrl (W=7), plus a random a*b sweep.
// Honours ZERO_SKIP_EN when it is defined for the build.
module tb_shift_add_mult_ctrl;

    localparam int unsigned W = 7;
    localparam int BOUND = 40;
    localparam int RUN_LAT = 7;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] last_prod;
    int lat;

    shift_add_mult_ctrl_if #(.W(W)) bus ();

    shift_add_mult_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Present operands for one edge, then scramble them to prove they are not re-sampled.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        step();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic wait_done(input string tag, input logic [63:0] held, output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < BOUND) begin
            check({tag, "_hold"}, 64'(bus.product), held);
            step();
            cycles++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    endtask

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef ZERO_SKIP_EN
        if (x == '0 || y == '0) return 0;
`endif
        return RUN_LAT;
    endfunction

    // Complete operation with latency/product/width checks.
    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int c;
        accept(x, y);
        check({tag, "_busy_after_accept"}, 64'(bus.busy), (exp_lat(x, y) == 0) ? 64'd0 : 64'd1);
        wait_done(tag, last_prod, c);
        check({tag, "_latency"}, 64'(c), 64'(exp_lat(x, y)));
        check({tag, "_product"}, 64'(bus.product), 64'(int'(x) * int'(y)));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        last_prod = 64'(int'(x) * int'(y));
        step();
        check({tag, "_done_width"}, 64'(bus.done), 64'd0);
        check({tag, "_product_kept"}, 64'(bus.product), last_prod);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        last_prod = 64'd0;
        step();
        step();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        rst = 1'b0;
        step();

        // 5*3 = 15, busy for 7 edges
        op("t1_5x3", 7'd5, 7'd3);
        // 127*127 = 16129 = 14'h3F01
        op("t2_127x127", 7'd127, 7'd127);
        op("b_1x1", 7'd1, 7'd1);
        op("b_127x1", 7'd127, 7'd1);
        op("b_1x127", 7'd1, 7'd127);
        op("b_64x2", 7'd64, 7'd2);

        // start held through RUN with other operands: ignored, then back-to-back 9*9
        bus.start = 1'b1;
        bus.a     = 7'd12;
        bus.b     = 7'd11;
        step();
        bus.a = 7'd9;
        bus.b = 7'd9;
        wait_done("t3_first", last_prod, lat);
        check("t3_first_latency", 64'(lat), 64'd7);
        check("t3_first_product", 64'(bus.product), 64'd132);
        last_prod = 64'd132;
        step();
        bus.start = 1'b0;
        check("t3_b2b_busy", 64'(bus.busy), 64'd1);
        check("t3_b2b_done_low", 64'(bus.done), 64'd0);
        check("t3_b2b_product_old", 64'(bus.product), 64'd132);
        wait_done("t3_second", last_prod, lat);
        check("t3_second_latency", 64'(lat), 64'd7);
        check("t3_second_product", 64'(bus.product), 64'd81);
        last_prod = 64'd81;
        step();

        // reset at step 3 of 100*50 aborts without a done pulse
        accept(7'd100, 7'd50);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_done", 64'(bus.done), 64'd0);
        check("t4_product", 64'(bus.product), 64'd0);
        last_prod = 64'd0;
        for (int i = 0; i < 10; i++) begin
            check("t4_no_done", 64'(bus.done), 64'd0);
            step();
        end
        op("t4_after_6x7", 7'd6, 7'd7);

        // zero operands
        op("t5_0x77", 7'd0, 7'd77);
        op("t5_77x0", 7'd77, 7'd0);
        op("t5_0x0", 7'd0, 7'd0);

        for (int i = 0; i < 1000; i++) begin
            op("rand", W'($urandom_range(0, 127)), W'($urandom_range(0, 127)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
